// File: rtl/dmem_bytelane.sv
// dmem_bytelane: MEM-stage data memory with byte, halfword and word access.
//
// Loads and stores use big-endian byte lanes. Offset 0 holds bits 31:24 and
// offset 3 holds bits 7:0. Sub-word loads are sign- or zero-extended. Reads
// are registered, so the result appears one cycle after the request and is
// qualified by read_valid. Misaligned, reserved-size and out-of-range
// requests raise registered error flags. Such requests neither write the
// array nor produce a read result.
//
// Parameters:
//   DEPTH   number of 32-bit words (power of 2, >= 4)
//   ADDR_W  byte address width (>= log2(DEPTH)+2)
//   IDLE_Z  1: read_data floats when no result is present, 0: drives zero
//
// Optional build macro:
//   DMEM_BYPASS_EN  forward the same-cycle store into a load of that word
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   mem_read          load request
//   mem_write         store request
//   mem_size          00 byte, 01 half, 10 word, 11 reserved (illegal)
//   load_unsigned     1: zero-extend sub-word loads, 0: sign-extend
//   addr              byte address
//   write_data        store data (low 8/16 bits for byte/half)
//   read_data         extended load result
//   read_valid        one-cycle strobe after an accepted load
//   align_err         registered misaligned / reserved-size flag
//   range_err         registered addr >= DEPTH*4 flag
module dmem_bytelane #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IDLE_Z = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              load_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              read_valid,
  output logic              align_err,
  output logic              range_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [31:0]      mem [DEPTH];

  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic             req;
  logic             misalign;
  logic             out_of_range;
  logic             accept;
  logic [3:0]       be;          // be[i] enables bits 8*i+7 : 8*i
  logic [31:0]      wdata_rep;
  logic [31:0]      old_word;
  logic [31:0]      src_word;
  logic [31:0]      load_ext;
  logic [31:0]      rd_q;

  assign idx = addr[IDX_W+1:2];
  assign off = addr[1:0];

  generate
    if (ADDR_W > IDX_W + 2) begin : g_range
      assign out_of_range = |addr[ADDR_W-1:IDX_W+2];
    end else begin : g_norange
      assign out_of_range = 1'b0;
    end
  endgenerate

  assign old_word = mem[idx];

  always_comb begin
    req       = mem_read | mem_write;
    misalign  = 1'b0;
    be        = '0;
    wdata_rep = write_data;
    case (mem_size)
      2'b00: begin
        be        = 4'b1000 >> off;
        wdata_rep = {4{write_data[7:0]}};
      end
      2'b01: begin
        misalign  = off[0];
        be        = off[1] ? 4'b0011 : 4'b1100;
        wdata_rep = {2{write_data[15:0]}};
      end
      2'b10: begin
        misalign  = |off;
        be        = 4'b1111;
      end
      default: misalign = 1'b1;
    endcase
    accept = req & ~misalign & ~out_of_range;
  end

  // With forwarding, the load sees the store's lanes merged over the array word.
  always_comb begin
    src_word = old_word;
`ifdef DMEM_BYPASS_EN
    if (accept && mem_write) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) src_word[8*i +: 8] = wdata_rep[8*i +: 8];
      end
    end
`endif
  end

  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = '0;
    h = '0;
    load_ext = src_word;
    case (mem_size)
      2'b00: begin
        case (off)
          2'd0:    b = src_word[31:24];
          2'd1:    b = src_word[23:16];
          2'd2:    b = src_word[15:8];
          default: b = src_word[7:0];
        endcase
        load_ext = {{24{b[7] & ~load_unsigned}}, b};
      end
      2'b01: begin
        h = off[1] ? src_word[15:0] : src_word[31:16];
        load_ext = {{16{h[15] & ~load_unsigned}}, h};
      end
      default: load_ext = src_word;
    endcase
  end

  // The array has no reset. Its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (accept && mem_write) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_valid <= 1'b0;
      rd_q       <= '0;
      align_err  <= 1'b0;
      range_err  <= 1'b0;
    end else begin
      read_valid <= accept & mem_read;
      rd_q       <= load_ext;
      align_err  <= req & misalign;
      range_err  <= req & out_of_range;
    end
  end

  generate
    if (IDLE_Z != 0) begin : g_idle_z
      assign read_data = read_valid ? rd_q : 32'bz;
    end else begin : g_idle_0
      assign read_data = read_valid ? rd_q : '0;
    end
  endgenerate

endmodule

// File: tb/tb_dmem_bytelane.sv
module tb_dmem_bytelane;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned NBYTE = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic        load_unsigned = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        read_valid;
  logic        align_err;
  logic        range_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Byte-addressed reference memory: m[a] is the byte at address a.
  logic [7:0] m [NBYTE];

  dmem_bytelane #(
    .DEPTH (DEPTH),
    .ADDR_W(32),
    .IDLE_Z(0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_size     (mem_size),
    .load_unsigned(load_unsigned),
    .addr         (addr),
    .write_data   (write_data),
    .read_data    (read_data),
    .read_valid   (read_valid),
    .align_err    (align_err),
    .range_err    (range_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input int a, input logic [1:0] sz, input bit uns);
    logic [31:0] v;
    case (sz)
      2'd0: begin
        v = {24'd0, m[a]};
        if (!uns && m[a][7]) v = v | 32'hFFFF_FF00;
      end
      2'd1: begin
        v = {16'd0, m[a], m[a+1]};
        if (!uns && m[a][7]) v = v | 32'hFFFF_0000;
      end
      default: v = {m[a], m[a+1], m[a+2], m[a+3]};
    endcase
    return v;
  endfunction

  task automatic model_store(input int a, input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'd0: m[a] = wd[7:0];
      2'd1: begin m[a] = wd[15:8]; m[a+1] = wd[7:0]; end
      default: begin
        m[a] = wd[31:24]; m[a+1] = wd[23:16]; m[a+2] = wd[15:8]; m[a+3] = wd[7:0];
      end
    endcase
  endtask

  // One request cycle: drive, update the model, then check the registered outputs.
  task automatic issue(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd);
    bit          req, mis, oor, ok;
    logic [31:0] exp_d;
    bit          exp_v;
    req   = rd | wr;
    mis   = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    oor   = (a >= NBYTE);
    ok    = req && !mis && !oor;
    exp_v = ok && rd;
    exp_d = '0;
    if (ok) begin
`ifdef DMEM_BYPASS_EN
      if (wr) model_store(int'(a), sz, wd);
      if (rd) exp_d = model_load(int'(a), sz, uns);
`else
      if (rd) exp_d = model_load(int'(a), sz, uns);
      if (wr) model_store(int'(a), sz, wd);
`endif
    end
    mem_read      = rd;
    mem_write     = wr;
    mem_size      = sz;
    load_unsigned = uns;
    addr          = a;
    write_data    = wd;
    @(posedge clk);
    #1;
    check("read_valid", {31'd0, read_valid}, {31'd0, exp_v});
    check("read_data",  read_data, exp_d);
    check("align_err",  {31'd0, align_err}, {31'd0, req && mis});
    check("range_err",  {31'd0, range_err}, {31'd0, req && oor});
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int unsigned r;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, read_valid}, 32'd0);
    check("rst_data",  read_data, 32'd0);
    check("rst_align", {31'd0, align_err}, 32'd0);
    check("rst_range", {31'd0, range_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int w = 0; w < int'(DEPTH); w++) issue(1'b0, 1'b1, 2'd2, 1'b0, 32'(w * 4), 32'd0);

    issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h8899AABB);
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    check("lw_10", read_data, 32'h8899AABB);
    issue(1'b1, 1'b0, 2'd0, 1'b0, 32'h11, 32'd0);
    check("lb_11", read_data, 32'hFFFFFF99);
    issue(1'b1, 1'b0, 2'd0, 1'b1, 32'h11, 32'd0);
    check("lbu_11", read_data, 32'h00000099);
    issue(1'b1, 1'b0, 2'd1, 1'b0, 32'h12, 32'd0);
    check("lh_12", read_data, 32'hFFFFAABB);
    issue(1'b1, 1'b0, 2'd1, 1'b1, 32'h12, 32'd0);
    check("lhu_12", read_data, 32'h0000AABB);
    issue(1'b0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h12345677);
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    check("lw_after_sb", read_data, 32'h8899AA77);
    issue(1'b0, 1'b1, 2'd1, 1'b0, 32'h10, 32'h00001234);
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    check("lw_after_sh", read_data, 32'h1234AA77);

    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h12, 32'd0);
    check("lw_mis_align", {31'd0, align_err}, 32'd1);
    issue(1'b0, 1'b1, 2'd1, 1'b0, 32'h11, 32'h0000FFFF);
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    check("sh_mis_nowrite", read_data, 32'h1234AA77);
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'(NBYTE), 32'd0);
    check("lw_range", {31'd0, range_err}, 32'd1);
    issue(1'b1, 1'b0, 2'd3, 1'b0, 32'h10, 32'd0);
    check("size_11", {31'd0, align_err}, 32'd1);

    issue(1'b1, 1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF);
`ifdef DMEM_BYPASS_EN
    check("rw_same_bypass", read_data, 32'hDEADBEEF);
`else
    check("rw_same_nobypass", read_data, 32'h00000000);
`endif
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
    check("lw_20_after", read_data, 32'hDEADBEEF);

    // Reset lands between a load request and its result.
    mem_read  = 1'b1;
    mem_write = 1'b0;
    mem_size  = 2'd2;
    addr      = 32'h10;
    #2;
    rst_n    = 1'b0;
    #1;
    mem_read = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_valid", {31'd0, read_valid}, 32'd0);
    check("rst_mid_data",  read_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", {31'd0, read_valid}, 32'd0);
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    check("lw_retained", read_data, 32'h1234AA77);

    for (int i = 0; i < 3000; i++) begin
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r  = $urandom_range(0, 31);
      if (r == 0)      a = $urandom;
      else if (r < 3)  a = 32'($urandom_range(NBYTE, NBYTE + 64));
      else             a = 32'($urandom_range(0, NBYTE - 1));
      if ($urandom_range(0, 1) == 1) begin
        if (sz == 2'd1) a = a & ~32'd1;
        if (sz == 2'd2) a = a & ~32'd3;
      end
      r = $urandom_range(0, 9);
      issue(r >= 2 && r <= 5 || r == 9, r >= 6, sz, 1'($urandom_range(0, 1)), a, $urandom);
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
